tile_map_arbiter: RTL and testbench

- Owns the single-port 80x60 tile-map RAM: 4800 entries of 4-bit tile index, 13-bit address.
- Shares the RAM between the VGA tile-fetch path and a tile-update writer.
- Display reads have absolute priority while bright is high. Writes and bulk screen clears are scheduled only while bright is low.
- Sits between the sync counters, the tile-map RAM and the tile-select/pixel stage.

---
 rtl/tile_map_arbiter_if.sv | 33 +++
 rtl/tile_map_arbiter.sv | 146 ++++++++++++++
 tb/tb_tile_map_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tile_map_arbiter_if.sv
// rtl/tile_map_arbiter_if.sv - signal bundle between sync counters, writer, tile-map RAM and pixel stage
// slave is the arbiter's view; master is the surrounding system.
interface tile_map_arbiter_if;
   logic [9:0]  hcount;
   logic [9:0]  vcount;
   logic        bright;
   logic        wr_valid;
   logic        wr_ready;
   logic [6:0]  wr_col;
   logic [5:0]  wr_row;
   logic [3:0]  wr_tile;
   logic        clr_start;
   logic [3:0]  clr_tile;
   logic        clr_busy;
   logic        bad_coord;
   logic [12:0] ram_addr;
   logic        ram_we;
   logic [3:0]  ram_din;
   logic [3:0]  ram_dout;
   logic [3:0]  tselect;

   modport slave (
      input  hcount, vcount, bright, wr_valid, wr_col, wr_row, wr_tile,
             clr_start, clr_tile, ram_dout,
      output wr_ready, clr_busy, bad_coord, ram_addr, ram_we, ram_din, tselect
   );

   modport master (
      output hcount, vcount, bright, wr_valid, wr_col, wr_row, wr_tile,
             clr_start, clr_tile, ram_dout,
      input  wr_ready, clr_busy, bad_coord, ram_addr, ram_we, ram_din, tselect
   );
endinterface

// File: rtl/tile_map_arbiter.sv
// rtl/tile_map_arbiter.sv - tile-map RAM arbiter: display reads, queued tile writes, bulk clear
// Display owns the RAM while bright; writes and clears only use blanking cycles.
module tile_map_arbiter #(
   parameter int HLEFT      = 145,
   parameter int VTOP       = 32,
   parameter int COLS       = 80,
   parameter int ROWS       = 60,
   parameter int FIFO_DEPTH = 4
) (
   input logic               clk,
   input logic               rst_n,
   tile_map_arbiter_if.slave bus
);
   localparam int          PW        = $clog2(FIFO_DEPTH);
   localparam logic [12:0] COLS_W    = 13'(COLS);
   localparam logic [12:0] LAST_ADDR = 13'(COLS * ROWS - 1);

   typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

   state_t      state_q;
   logic [12:0] fifo_addr_q [FIFO_DEPTH];
   logic [3:0]  fifo_data_q [FIFO_DEPTH];
   logic [PW-1:0] wptr_q, rptr_q;
   logic [PW:0] count_q, count_d;
   logic [12:0] clr_cnt_q;
   logic [3:0]  clr_tile_q;
   logic        clr_busy_q;
   logic        bad_coord_q;
   logic [3:0]  tselect_q;

   logic [12:0] h_off, v_off, disp_addr, wr_addr;
   logic        full, bad, push, store, pop, start_clear;
   logic [12:0] ram_addr_d;
   logic        ram_we_d;
   logic [3:0]  ram_din_d;

   assign h_off     = 13'(bus.hcount) - 13'(HLEFT);
   assign v_off     = 13'(bus.vcount) - 13'(VTOP);
   assign disp_addr = (v_off >> 3) * COLS_W + (h_off >> 3);
   assign wr_addr   = 13'(bus.wr_row) * COLS_W + 13'(bus.wr_col);

   // Out-of-range requests are still handshaken so the writer never stalls on them.
   assign bad         = (32'(bus.wr_col) >= COLS) || (32'(bus.wr_row) >= ROWS);
   assign full        = (count_q == (PW+1)'(FIFO_DEPTH));
   assign push        = bus.wr_valid && !full;
   assign store       = push && !bad;
   assign pop         = (state_q == DRAIN) && !bus.bright && (count_q != '0);
   assign start_clear = bus.clr_start && !clr_busy_q;

   always_comb begin
      count_d = count_q;
      if (store && !pop) begin
         count_d = count_q + (PW+1)'(1);
      end else if (!store && pop) begin
         count_d = count_q - (PW+1)'(1);
      end
   end

   // bright gates writes combinationally so a mid-drain rise never corrupts a display read.
   always_comb begin
      ram_addr_d = '0;
      ram_we_d   = 1'b0;
      ram_din_d  = '0;
      if (bus.bright) begin
         ram_addr_d = disp_addr;
      end else if (state_q == DRAIN && count_q != '0) begin
         ram_addr_d = fifo_addr_q[rptr_q];
         ram_din_d  = fifo_data_q[rptr_q];
         ram_we_d   = 1'b1;
      end else if (state_q == CLEAR) begin
         ram_addr_d = clr_cnt_q;
         ram_din_d  = clr_tile_q;
         ram_we_d   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (store) begin
         fifo_addr_q[wptr_q] <= wr_addr;
         fifo_data_q[wptr_q] <= bus.wr_tile;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         wptr_q      <= '0;
         rptr_q      <= '0;
         count_q     <= '0;
         clr_cnt_q   <= '0;
         clr_tile_q  <= '0;
         clr_busy_q  <= 1'b0;
         bad_coord_q <= 1'b0;
         tselect_q   <= '0;
      end else begin
         count_q     <= count_d;
         bad_coord_q <= push && bad;
         if (store) wptr_q <= wptr_q + PW'(1);
         if (pop)   rptr_q <= rptr_q + PW'(1);
         if (bus.bright) tselect_q <= bus.ram_dout;

         unique case (state_q)
            IDLE: begin
               if (start_clear) begin
                  state_q    <= CLEAR;
                  clr_busy_q <= 1'b1;
                  clr_cnt_q  <= '0;
                  clr_tile_q <= bus.clr_tile;
               end else if (count_q != '0 && !bus.bright) begin
                  state_q <= DRAIN;
               end
            end
            DRAIN: begin
               if (start_clear) begin
                  state_q    <= CLEAR;
                  clr_busy_q <= 1'b1;
                  clr_cnt_q  <= '0;
                  clr_tile_q <= bus.clr_tile;
               end else if (bus.bright || count_d == '0) begin
                  state_q <= IDLE;
               end
            end
            CLEAR: begin
               if (!bus.bright) begin
                  if (clr_cnt_q == LAST_ADDR) begin
                     state_q    <= IDLE;
                     clr_cnt_q  <= '0;
                     clr_busy_q <= 1'b0;
                  end else begin
                     clr_cnt_q <= clr_cnt_q + 13'd1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.wr_ready  = !full;
   assign bus.clr_busy  = clr_busy_q;
   assign bus.bad_coord = bad_coord_q;
   assign bus.ram_addr  = ram_addr_d;
   assign bus.ram_we    = ram_we_d;
   assign bus.ram_din   = ram_din_d;
   assign bus.tselect   = tselect_q;
endmodule

// File: tb/tb_tile_map_arbiter.sv
// tb/tb_tile_map_arbiter.sv - directed and randomized bench for tile_map_arbiter
module tb_tile_map_arbiter;
   logic clk = 1'b0;
   logic rst_n;
   tile_map_arbiter_if bus();

   tile_map_arbiter dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {int cyc; int addr; int data;} wr_t;
   typedef struct {int addr; int data;} ent_t;

   logic [3:0] mem [4800];
   wr_t  wlog [$];
   ent_t model [$];
   int   cycle = 0;
   int   bright_viol = 0;
   int   errors = 0;
   int   checks = 0;
   int   seen = 0;

   always #5 clk = ~clk;

   assign bus.ram_dout = (bus.ram_addr < 13'd4800) ? mem[bus.ram_addr] : 4'd0;

   // RAM model: a write visible at the negedge commits at the following posedge.
   always @(negedge clk) begin
      wr_t w;
      cycle++;
      if (bus.ram_we) begin
         if (bus.bright) bright_viol++;
         if (bus.ram_addr < 13'd4800) mem[bus.ram_addr] = bus.ram_din;
         w.cyc  = cycle;
         w.addr = int'(bus.ram_addr);
         w.data = int'(bus.ram_din);
         wlog.push_back(w);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      #3;
   endtask

   task automatic match_writes();
      ent_t e;
      while (seen < wlog.size()) begin
         chk("rnd_write_expected", 32'(model.size() != 0), 32'd1);
         if (model.size() != 0) begin
            e = model.pop_front();
            chk("rnd_waddr", 32'(wlog[seen].addr), 32'(e.addr));
            chk("rnd_wdata", 32'(wlog[seen].data), 32'(e.data));
         end
         seen++;
      end
   endtask

   initial begin
      bit   found, acc, good, done, acc5;
      int   ga, gd, run, nbad_hits, nbad_data;
      int   hits [4800];
      logic expect_bad;
      logic [3:0] exp_tsel, nxt_tsel;
      ent_t e;

      rst_n = 1'b0;
      bus.hcount = '0; bus.vcount = '0; bus.bright = 1'b0;
      bus.wr_valid = 1'b0; bus.wr_col = '0; bus.wr_row = '0; bus.wr_tile = '0;
      bus.clr_start = 1'b0; bus.clr_tile = '0;
      for (int i = 0; i < 4800; i++) mem[i] = 4'($urandom_range(0, 15));

      cyc(); mid();
      chk("rst_wr_ready",  32'(bus.wr_ready),  32'd1);
      chk("rst_clr_busy",  32'(bus.clr_busy),  32'd0);
      chk("rst_bad_coord", 32'(bus.bad_coord), 32'd0);
      chk("rst_ram_we",    32'(bus.ram_we),    32'd0);
      chk("rst_ram_addr",  32'(bus.ram_addr),  32'd0);
      chk("rst_ram_din",   32'(bus.ram_din),   32'd0);
      chk("rst_tselect",   32'(bus.tselect),   32'd0);
      cyc();
      rst_n = 1'b1;

      // display read
      mem[81] = 4'hA;
      bus.bright = 1'b1; bus.hcount = 10'd153; bus.vcount = 10'd40;
      mid();
      chk("disp_addr", 32'(bus.ram_addr), 32'd81);
      chk("disp_we",   32'(bus.ram_we),   32'd0);
      cyc(); mid();
      chk("disp_tsel", 32'(bus.tselect), 32'hA);
      cyc();

      // blank-time write
      bus.bright = 1'b0; wlog.delete();
      bus.wr_valid = 1'b1; bus.wr_col = 7'd5; bus.wr_row = 6'd2; bus.wr_tile = 4'd7;
      mid();
      chk("blank_ready", 32'(bus.wr_ready), 32'd1);
      cyc();
      bus.wr_valid = 1'b0;
      found = 1'b0; ga = 0; gd = 0;
      for (int k = 0; k < 3 && !found; k++) begin
         mid();
         if (bus.ram_we) begin found = 1'b1; ga = int'(bus.ram_addr); gd = int'(bus.ram_din); end
         cyc();
      end
      chk("blank_we_seen", 32'(found), 32'd1);
      chk("blank_addr", 32'(ga), 32'd165);
      chk("blank_din",  32'(gd), 32'd7);
      repeat (4) cyc();
      chk("blank_one_write", 32'(wlog.size()), 32'd1);

      // backpressure
      bus.bright = 1'b1; bus.hcount = 10'd200; bus.vcount = 10'd100; wlog.delete();
      for (int k = 0; k < 4; k++) begin
         bus.wr_valid = 1'b1; bus.wr_col = 7'(k); bus.wr_row = 6'd1; bus.wr_tile = 4'(k + 1);
         mid();
         chk("bp_ready", 32'(bus.wr_ready), 32'd1);
         cyc();
      end
      bus.wr_col = 7'd4; bus.wr_tile = 4'd5;
      repeat (4) begin
         mid();
         chk("bp_full", 32'(bus.wr_ready), 32'd0);
         cyc();
      end
      chk("bp_no_write_bright", 32'(wlog.size()), 32'd0);
      bus.bright = 1'b0;
      acc5 = 1'b0;
      for (int k = 0; k < 10 && !acc5; k++) begin
         mid();
         if (bus.wr_ready) acc5 = 1'b1;
         cyc();
      end
      bus.wr_valid = 1'b0;
      chk("bp_fifth_accepted", 32'(acc5), 32'd1);
      for (int k = 0; k < 20 && wlog.size() < 5; k++) cyc();
      chk("bp_write_count", 32'(wlog.size()), 32'd5);
      if (wlog.size() == 5) begin
         for (int k = 0; k < 5; k++) begin
            chk("bp_order_addr", 32'(wlog[k].addr), 32'(80 + k));
            chk("bp_order_data", 32'(wlog[k].data), 32'(k + 1));
         end
         for (int k = 0; k < 3; k++) chk("bp_one_per_clk", 32'(wlog[k+1].cyc - wlog[k].cyc), 32'd1);
      end

      // bright rising mid-drain
      bus.bright = 1'b1; wlog.delete();
      for (int k = 0; k < 4; k++) begin
         bus.wr_valid = 1'b1; bus.wr_col = 7'(10 + k); bus.wr_row = 6'd3; bus.wr_tile = 4'(8 + k);
         cyc();
      end
      bus.wr_valid = 1'b0; bus.bright = 1'b0;
      for (int k = 0; k < 20 && wlog.size() < 2; k++) cyc();
      chk("gate_two_written", 32'(wlog.size()), 32'd2);
      bus.bright = 1'b1;
      mid();
      chk("gate_we_low", 32'(bus.ram_we), 32'd0);
      cyc();
      repeat (5) cyc();
      chk("gate_retained", 32'(wlog.size()), 32'd2);
      bus.bright = 1'b0;
      for (int k = 0; k < 20 && wlog.size() < 4; k++) cyc();
      chk("gate_all_written", 32'(wlog.size()), 32'd4);
      if (wlog.size() == 4) begin
         for (int k = 0; k < 4; k++) begin
            chk("gate_addr", 32'(wlog[k].addr), 32'(250 + k));
            chk("gate_data", 32'(wlog[k].data), 32'(8 + k));
         end
      end

      // full-map clear with bright toggling, a queued write and an ignored restart
      wlog.delete(); bus.bright = 1'b0;
      bus.clr_tile = 4'd3; bus.clr_start = 1'b1;
      mid(); cyc();
      bus.clr_start = 1'b0; bus.clr_tile = 4'd5;
      mid();
      chk("clr_busy_rise", 32'(bus.clr_busy), 32'd1);
      cyc();
      done = 1'b0;
      for (int n = 0; n < 20000 && !done; n++) begin
         bus.bright    = ((n / 1000) % 2) == 1;
         bus.hcount    = 10'($urandom_range(145, 784));
         bus.vcount    = 10'($urandom_range(32, 511));
         bus.clr_start = (n == 1500);
         bus.wr_valid  = (n == 10);
         bus.wr_col = 7'd1; bus.wr_row = 6'd0; bus.wr_tile = 4'd9;
         mid();
         if (n == 10) chk("clr_push_ready", 32'(bus.wr_ready), 32'd1);
         if (!bus.clr_busy) done = 1'b1;
         else cyc();
      end
      bus.clr_start = 1'b0; bus.wr_valid = 1'b0;
      chk("clr_done", 32'(done), 32'd1);
      chk("clr_write_count", 32'(wlog.size()), 32'd4800);
      if (wlog.size() != 0) begin
         chk("clr_last_addr", 32'(wlog[wlog.size()-1].addr), 32'd4799);
         chk("clr_last_when_busy_falls", 32'(wlog[wlog.size()-1].cyc), 32'(cycle));
      end
      for (int i = 0; i < 4800; i++) hits[i] = 0;
      nbad_data = 0;
      foreach (wlog[i]) begin
         if (wlog[i].addr >= 0 && wlog[i].addr < 4800) hits[wlog[i].addr]++;
         if (wlog[i].data != 3) nbad_data++;
      end
      nbad_hits = 0;
      for (int i = 0; i < 4800; i++) if (hits[i] != 1) nbad_hits++;
      chk("clr_each_addr_once", 32'(nbad_hits), 32'd0);
      chk("clr_data", 32'(nbad_data), 32'd0);
      cyc();
      bus.bright = 1'b0;
      for (int k = 0; k < 20 && wlog.size() < 4801; k++) cyc();
      chk("clr_queued_count", 32'(wlog.size()), 32'd4801);
      if (wlog.size() == 4801) begin
         chk("clr_queued_addr", 32'(wlog[4800].addr), 32'd1);
         chk("clr_queued_data", 32'(wlog[4800].data), 32'd9);
      end

      // bad coordinates
      wlog.delete();
      bus.wr_valid = 1'b1; bus.wr_col = 7'd80; bus.wr_row = 6'd0; bus.wr_tile = 4'd2;
      mid();
      chk("bad_ready", 32'(bus.wr_ready), 32'd1);
      cyc();
      bus.wr_valid = 1'b0;
      mid();
      chk("bad_pulse", 32'(bus.bad_coord), 32'd1);
      cyc(); mid();
      chk("bad_one_clk", 32'(bus.bad_coord), 32'd0);
      cyc();
      bus.wr_valid = 1'b1; bus.wr_col = 7'd0; bus.wr_row = 6'd60;
      cyc();
      bus.wr_valid = 1'b0;
      mid();
      chk("bad_row_pulse", 32'(bus.bad_coord), 32'd1);
      cyc();
      repeat (4) cyc();
      chk("bad_no_write", 32'(wlog.size()), 32'd0);

      // asynchronous reset mid-clear with a full FIFO
      bus.clr_tile = 4'd6; bus.clr_start = 1'b1;
      cyc();
      bus.clr_start = 1'b0;
      repeat (100) cyc();
      bus.bright = 1'b1; bus.hcount = 10'd300; bus.vcount = 10'd200;
      for (int k = 0; k < 4; k++) begin
         bus.wr_valid = 1'b1; bus.wr_col = 7'(k); bus.wr_row = 6'd5; bus.wr_tile = 4'd1;
         cyc();
      end
      bus.wr_valid = 1'b0;
      mid();
      chk("rstc_full", 32'(bus.wr_ready), 32'd0);
      chk("rstc_busy_before", 32'(bus.clr_busy), 32'd1);
      cyc();
      rst_n = 1'b0;
      mid();
      chk("rstc_clr_busy", 32'(bus.clr_busy), 32'd0);
      chk("rstc_ram_we",   32'(bus.ram_we),   32'd0);
      chk("rstc_fifo_empty", 32'(bus.wr_ready), 32'd1);
      chk("rstc_tselect",  32'(bus.tselect),  32'd0);
      cyc(); cyc();
      bus.bright = 1'b0;
      cyc();
      rst_n = 1'b1; wlog.delete();
      repeat (10) cyc();
      mid();
      chk("rstc_flushed", 32'(wlog.size()), 32'd0);
      chk("rstc_idle", 32'(bus.clr_busy), 32'd0);
      cyc();

      // randomized traffic against a queue model
      model.delete(); wlog.delete(); seen = 0;
      exp_tsel = 4'd0; expect_bad = 1'b0; run = 0;
      for (int it = 0; it < 600; it++) begin
         if (run == 0) begin
            bus.bright = ~bus.bright;
            run = $urandom_range(1, 12);
         end
         run--;
         bus.hcount   = 10'($urandom_range(145, 784));
         bus.vcount   = 10'($urandom_range(32, 511));
         bus.wr_valid = ($urandom_range(0, 2) != 0);
         bus.wr_col   = ($urandom_range(0, 15) == 0) ? 7'($urandom_range(80, 127)) : 7'($urandom_range(0, 79));
         bus.wr_row   = ($urandom_range(0, 15) == 0) ? 6'($urandom_range(60, 63)) : 6'($urandom_range(0, 59));
         bus.wr_tile  = 4'($urandom_range(0, 15));
         mid();
         chk("rnd_ready", 32'(bus.wr_ready), 32'(model.size() < 4));
         chk("rnd_bad",   32'(bus.bad_coord), 32'(expect_bad));
         chk("rnd_tsel",  32'(bus.tselect), 32'(exp_tsel));
         if (bus.bright) chk("rnd_we_gated", 32'(bus.ram_we), 32'd0);
         acc  = bus.wr_valid && bus.wr_ready;
         good = (int'(bus.wr_col) < 80) && (int'(bus.wr_row) < 60);
         e.addr = int'(bus.wr_row) * 80 + int'(bus.wr_col);
         e.data = int'(bus.wr_tile);
         if (bus.bright)
            nxt_tsel = mem[((int'(bus.vcount) - 32) / 8) * 80 + (int'(bus.hcount) - 145) / 8];
         else
            nxt_tsel = exp_tsel;
         cyc();
         match_writes();
         if (acc && good) model.push_back(e);
         expect_bad = acc && !good;
         exp_tsel   = nxt_tsel;
      end
      bus.bright = 1'b0; bus.wr_valid = 1'b0;
      for (int k = 0; k < 20 && model.size() != 0; k++) begin
         cyc();
         match_writes();
      end
      chk("rnd_drained", 32'(model.size()), 32'd0);
      chk("no_write_while_bright", 32'(bright_viol), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
